// File: rtl/qed_dup_encoder.sv
// QED duplicate encoder: buffers original RV32 R/I ALU instructions in order and
// replays them as shadow-register duplicates (x1..x15 -> x17..x31) over a valid/ready stream.
module qed_dup_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             qed_enable,
    input  logic [31:0]      ifu_qed_instruction,
    input  logic             ifu_valid,
    output logic             ifu_ready,
    input  logic             exec_dup,
    output logic [31:0]      dup_instruction,
    output logic             dup_valid,
    input  logic             dup_ready,
    output logic             dup_illegal,
    output logic [CNT_W-1:0] fifo_count,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_DUP  = 1'b1;
    localparam logic [6:0]       OP_R    = 7'b0110011;
    localparam logic [6:0]       OP_I    = 7'b0010011;
    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

    // x0 stays x0; every other architectural register moves to the shadow half.
    function automatic logic [4:0] remap(input logic [4:0] r);
        logic [4:0] res;
        if (r == 5'd0) begin
            res = 5'd0;
        end else begin
            res = r + 5'd16;
        end
        return res;
    endfunction

    // Returns {illegal, instruction}; anything not encodable becomes a flagged NOP.
    function automatic logic [32:0] encode_dup(input logic [31:0] insn);
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] enc;
        logic        bad;
        rd  = insn[11:7];
        rs1 = insn[19:15];
        rs2 = insn[24:20];
        case (insn[6:0])
            OP_R: begin
                bad = rd[4] | rs1[4] | rs2[4];
                enc = {insn[31:25], remap(rs2), remap(rs1), insn[14:12], remap(rd), insn[6:0]};
            end
            OP_I: begin
                bad = rd[4] | rs1[4];
                enc = {insn[31:20], remap(rs1), insn[14:12], remap(rd), insn[6:0]};
            end
            default: begin
                bad = 1'b1;
                enc = NOP;
            end
        endcase
        if (bad) begin
            return {1'b1, NOP};
        end else begin
            return {1'b0, enc};
        end
    endfunction

    logic [31:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [0:0]       state_r, state_s;
    logic             busy_r;
    logic             dup_valid_r, dup_valid_s;
    logic [31:0]      dup_instr_r, dup_instr_s;
    logic             dup_illegal_r, dup_illegal_s;
    logic             ifu_ready_s;
    logic             push_s;
    logic             pop_s;
    logic [32:0]      enc_s;

    // Handshake qualifiers for buffer push and replay pop.
    always_comb begin
        ifu_ready_s = qed_enable && (state_r == ST_IDLE) && (count_r < DEPTH_C);
        push_s      = ifu_valid && ifu_ready_s;
        pop_s       = qed_enable && (state_r == ST_DUP) && (count_r != '0)
                      && (!dup_valid_r || dup_ready);
        enc_s       = encode_dup(fifo_mem_r[rd_ptr_r]);
    end

    // Next-state computation for the controller, pointers and output stage.
    always_comb begin
        state_s       = state_r;
        wr_ptr_s      = wr_ptr_r;
        rd_ptr_s      = rd_ptr_r;
        count_s       = count_r;
        dup_valid_s   = dup_valid_r;
        dup_instr_s   = dup_instr_r;
        dup_illegal_s = dup_illegal_r;
        if (!qed_enable) begin
            state_s     = ST_IDLE;
            wr_ptr_s    = '0;
            rd_ptr_s    = '0;
            count_s     = '0;
            dup_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (push_s) begin
                        wr_ptr_s = wr_ptr_r + PTR_ONE;
                        count_s  = count_r + CNT_ONE;
                    end else begin
                        wr_ptr_s = wr_ptr_r;
                    end
                    // A same-cycle push counts toward starting the replay.
                    if (exec_dup && ((count_r != '0) || push_s)) begin
                        state_s = ST_DUP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DUP: begin
                    if (pop_s) begin
                        rd_ptr_s      = rd_ptr_r + PTR_ONE;
                        count_s       = count_r - CNT_ONE;
                        dup_valid_s   = 1'b1;
                        dup_instr_s   = enc_s[31:0];
                        dup_illegal_s = enc_s[32];
                    end else if (dup_valid_r && dup_ready) begin
                        dup_valid_s = 1'b0;
                    end else begin
                        dup_valid_s = dup_valid_r;
                    end
                    if ((count_r == '0) && (!dup_valid_r || dup_ready)) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DUP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            dup_valid_r   <= 1'b0;
            dup_instr_r   <= 32'h0000_0000;
            dup_illegal_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            busy_r        <= (state_s == ST_DUP);
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            count_r       <= count_s;
            dup_valid_r   <= dup_valid_s;
            dup_instr_r   <= dup_instr_s;
            dup_illegal_r <= dup_illegal_s;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= ifu_qed_instruction;
        end
    end

    assign ifu_ready       = ifu_ready_s;
    assign dup_instruction = dup_instr_r;
    assign dup_valid       = dup_valid_r;
    assign dup_illegal     = dup_illegal_r;
    assign fifo_count      = count_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_qed_dup_encoder.sv
// Directed bench for qed_dup_encoder: a vector table for single-instruction
// replays plus sequences for full/backpressure, illegal pairs, reset and flush.
module tb_qed_dup_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        qed_enable;
    logic [31:0] ifu_qed_instruction;
    logic        ifu_valid;
    logic        ifu_ready;
    logic        exec_dup;
    logic [31:0] dup_instruction;
    logic        dup_valid;
    logic        dup_ready;
    logic        dup_illegal;
    logic [3:0]  fifo_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] dup;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    qed_dup_encoder #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .qed_enable          (qed_enable),
        .ifu_qed_instruction (ifu_qed_instruction),
        .ifu_valid           (ifu_valid),
        .ifu_ready           (ifu_ready),
        .exec_dup            (exec_dup),
        .dup_instruction     (dup_instruction),
        .dup_valid           (dup_valid),
        .dup_ready           (dup_ready),
        .dup_illegal         (dup_illegal),
        .fifo_count          (fifo_count),
        .busy                (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [31:0] insn);
        ifu_valid           = 1'b1;
        ifu_qed_instruction = insn;
        step();
        ifu_valid           = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0020_81B3, 32'h0128_89B3, 1'b0}; // add x3,x1,x2
        vecs[1] = '{32'h0070_0293, 32'h0070_0A93, 1'b0}; // addi x5,x0,7
        vecs[2] = '{32'h0020_88B3, 32'h0000_0013, 1'b1}; // add x17,x1,x2
        vecs[3] = '{32'h0000_2083, 32'h0000_0013, 1'b1}; // lw
        vecs[4] = '{32'h4033_5393, 32'h403B_5B93, 1'b0}; // srai x7,x6,3
        vecs[5] = '{32'h40D7_07B3, 32'h41DF_0FB3, 1'b0}; // sub x15,x14,x13
        vecs[6] = '{32'h0101_00B3, 32'h0000_0013, 1'b1}; // add x1,x2,x16
        vecs[7] = '{32'h0000_0033, 32'h0000_0033, 1'b0}; // add x0,x0,x0
        vecs[8] = '{32'h0018_0093, 32'h0000_0013, 1'b1}; // addi x1,x16,1
        vecs[9] = '{32'hFFF5_C513, 32'hFFFD_CD13, 1'b0}; // xori x10,x11,-1

        rst_n = 1'b0; qed_enable = 1'b1; ifu_valid = 1'b0; ifu_qed_instruction = 32'h0;
        exec_dup = 1'b0; dup_ready = 1'b1;
        step(); step();
        chk("rst_dup_valid", dup_valid, 1'b0);
        chk("rst_dup_insn", dup_instruction, 32'h0);
        chk("rst_dup_ill", dup_illegal, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 4'd0);
        chk("rst_ifu_ready", ifu_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // exec_dup with an empty buffer must not start a replay
        exec_dup = 1'b1; step(); exec_dup = 1'b0;
        chk("empty_exec_busy", busy, 1'b0);
        step();
        chk("empty_exec_busy2", busy, 1'b0);

        for (int i = 0; i < 10; i++) begin
            push_one(vecs[i].insn);
            chk("tbl_count_push", fifo_count, 4'd1);
            exec_dup = 1'b1; dup_ready = 1'b1;
            step();
            exec_dup = 1'b0;
            chk("tbl_busy_t1", busy, 1'b1);
            chk("tbl_valid_t1", dup_valid, 1'b0);
            step();
            chk("tbl_valid_t2", dup_valid, 1'b1);
            chk("tbl_insn", dup_instruction, vecs[i].dup);
            chk("tbl_ill", dup_illegal, vecs[i].ill);
            step();
            chk("tbl_valid_t3", dup_valid, 1'b0);
            chk("tbl_busy_t3", busy, 1'b0);
            chk("tbl_count_t3", fifo_count, 4'd0);
        end

        // Two illegal originals replayed back to back
        push_one(32'h0020_88B3);
        push_one(32'h0000_2083);
        exec_dup = 1'b1; step(); exec_dup = 1'b0;
        step();
        chk("ill1_valid", dup_valid, 1'b1);
        chk("ill1_insn", dup_instruction, 32'h0000_0013);
        chk("ill1_flag", dup_illegal, 1'b1);
        step();
        chk("ill2_valid", dup_valid, 1'b1);
        chk("ill2_insn", dup_instruction, 32'h0000_0013);
        chk("ill2_flag", dup_illegal, 1'b1);
        step();
        chk("ill_done_valid", dup_valid, 1'b0);
        chk("ill_done_busy", busy, 1'b0);

        // Simultaneous push and exec_dup from empty
        ifu_valid = 1'b1; ifu_qed_instruction = 32'h0070_0293; exec_dup = 1'b1;
        step();
        ifu_valid = 1'b0; exec_dup = 1'b0;
        chk("sim_busy", busy, 1'b1);
        chk("sim_count", fifo_count, 4'd1);
        step();
        chk("sim_valid", dup_valid, 1'b1);
        chk("sim_insn", dup_instruction, 32'h0070_0A93);
        step();
        chk("sim_done_valid", dup_valid, 1'b0);
        chk("sim_done_busy", busy, 1'b0);

        // Fill: addi x1,x0,k for k=1..9; the 9th must be refused
        for (int k = 1; k <= 8; k++) begin
            #1 chk("fill_ready", ifu_ready, 1'b1);
            push_one((32'(k) << 20) | 32'h0000_0093);
        end
        ifu_valid = 1'b1; ifu_qed_instruction = (32'd9 << 20) | 32'h0000_0093;
        #1;
        chk("full_ready", ifu_ready, 1'b0);
        chk("full_count", fifo_count, 4'd8);
        step();
        ifu_valid = 1'b0;
        chk("full_count_after", fifo_count, 4'd8);

        begin
            int          got;
            logic        stalled;
            logic [31:0] held;
            got = 0; stalled = 1'b0; held = 32'h0;
            exec_dup = 1'b1; dup_ready = 1'b0;
            step();
            exec_dup = 1'b0;
            for (int c = 0; c < 60 && got < 8; c++) begin
                if (stalled) begin
                    chk("bp_hold_valid", dup_valid, 1'b1);
                    chk("bp_hold_insn", dup_instruction, held);
                end else if (dup_valid) begin
                    chk("bp_order", dup_instruction, (32'(got + 1) << 20) | 32'h0000_0893);
                    chk("bp_ill", dup_illegal, 1'b0);
                end
                dup_ready = (c % 3 == 0);
                if (dup_valid && dup_ready) begin
                    got++;
                    stalled = 1'b0;
                end else if (dup_valid) begin
                    stalled = 1'b1;
                    held    = dup_instruction;
                end else begin
                    stalled = 1'b0;
                end
                step();
            end
            chk("bp_dup_total", 32'(got), 32'd8);
            chk("bp_end_busy", busy, 1'b0);
            chk("bp_end_valid", dup_valid, 1'b0);
            chk("bp_end_count", fifo_count, 4'd0);
        end
        dup_ready = 1'b1;

        // Reset mid-DUP with a stalled dup
        push_one(vecs[0].insn); push_one(vecs[1].insn); push_one(vecs[4].insn);
        dup_ready = 1'b0; exec_dup = 1'b1; step(); exec_dup = 1'b0;
        step();
        chk("mid_rst_pre_valid", dup_valid, 1'b1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mid_rst_valid", dup_valid, 1'b0);
        chk("mid_rst_insn", dup_instruction, 32'h0);
        chk("mid_rst_ill", dup_illegal, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_count", fifo_count, 4'd0);
        chk("mid_rst_ready", ifu_ready, 1'b1);

        // Flush by dropping qed_enable mid-DUP
        push_one(vecs[5].insn); push_one(vecs[9].insn);
        exec_dup = 1'b1; step(); exec_dup = 1'b0;
        step();
        chk("flush_pre_valid", dup_valid, 1'b1);
        qed_enable = 1'b0;
        step();
        chk("flush_count", fifo_count, 4'd0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_valid", dup_valid, 1'b0);
        chk("flush_ready_low", ifu_ready, 1'b0);
        qed_enable = 1'b1; dup_ready = 1'b1;
        #1 chk("flush_ready_back", ifu_ready, 1'b1);

        // Buffer must be usable again after the flush
        step();
        push_one(vecs[9].insn);
        exec_dup = 1'b1; step(); exec_dup = 1'b0;
        step();
        chk("post_flush_insn", dup_instruction, vecs[9].dup);
        chk("post_flush_valid", dup_valid, 1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
